// File: rtl/soc_timer_if.sv
// soc_timer_if: SoC_MemBus, single-beat memory-mapped bus; reads return rdata with rvalid.
interface SoC_MemBus;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    modport Master(output req, we, addr, wdata, input rdata, rvalid);
    modport Slave(input req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/soc_timer.sv
// soc_timer: TIMER_COUNT prescaled wrap-around timers behind SoC_MemBus.
// Define SOC_TIMER_IRQ_EN to enable the wrap interrupt (CONTROL bit8 and irq).
module soc_peripheral_controller #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        res,
    SoC_MemBus.Slave    bus,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rd_data
);
    logic [LATENCY-1:0] vld;
    logic [31:0]        dat [LATENCY];
    assign wr    = bus.req && bus.we;
    assign addr  = bus.addr;
    assign wdata = bus.wdata;
    assign bus.rvalid = vld[LATENCY-1];
    assign bus.rdata  = dat[LATENCY-1];
    // Read data is captured from the registers on the request edge, then delayed.
    always_ff @(posedge clk) begin
        if (!res) begin
            vld <= '0;
            for (int k = 0; k < LATENCY; k++) dat[k] <= '0;
        end else begin
            for (int k = LATENCY - 1; k > 0; k--) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
            end
            vld[0] <= bus.req && !bus.we;
            dat[0] <= rd_data;
        end
    end
endmodule

module soc_timer #(
    parameter int BUS_LATENCY = 1,
    parameter int TIMER_COUNT = 1
) (
    input  logic        clk,
    input  logic        res,
    output logic [31:0] timer_counts [TIMER_COUNT],
    output logic        irq,
    SoC_MemBus.Slave    mem_bus
);
    logic        wr;
    logic [31:0] addr, wdata, rd_data;
    logic [3:0]  idx, rsel;
    logic [1:0]  typ;
    logic        main_wr;
    logic [31:0] rv [TIMER_COUNT];
    logic        unused_addr;
`ifdef SOC_TIMER_IRQ_EN
    logic [TIMER_COUNT-1:0] irq_src;
`endif
    soc_peripheral_controller #(.LATENCY(BUS_LATENCY)) u_ctrl (
        .clk(clk), .res(res), .bus(mem_bus),
        .wr(wr), .addr(addr), .wdata(wdata), .rd_data(rd_data)
    );
    assign idx = addr[11:8];
    assign rsel = addr[7:4];
    assign typ = addr[3:2];
    assign main_wr = wr && typ == 2'd0;
    assign unused_addr = ^{addr[31:12], addr[1:0]};
    for (genvar i = 0; i < TIMER_COUNT; i++) begin : g_t
        logic        en, os, ie, flag;
        logic [31:0] top, cnt;
        logic [15:0] pre, pcnt;
        logic        hit, tick, cnt_wr, wrap;
        assign hit = main_wr && idx == 4'(i);
        assign tick = en && pcnt == pre;
        assign cnt_wr = hit && rsel == 4'd3;
        // A bus write to COUNT swallows a coincident tick, including its wrap.
        assign wrap = tick && !cnt_wr && cnt >= top;
        always_ff @(posedge clk) begin
            if (!res) begin
                en <= 1'b0;
                os <= 1'b0;
                top <= '0;
                pre <= '0;
                pcnt <= '0;
                cnt <= '0;
                flag <= 1'b0;
            end else begin
                pcnt <= (!en || tick) ? 16'd0 : pcnt + 16'd1;
                cnt <= cnt_wr ? wdata : !tick ? cnt : cnt >= top ? 32'd0 : cnt + 32'd1;
                flag <= wrap || ((hit && rsel == 4'd4) ? wdata[0] : flag);
                top <= (hit && rsel == 4'd1) ? wdata : top;
                pre <= (hit && rsel == 4'd2) ? wdata[15:0] : pre;
                en <= (wrap && os) ? 1'b0 : (hit && rsel == 4'd0) ? wdata[0] : en;
                os <= (hit && rsel == 4'd0) ? wdata[1] : os;
            end
        end
`ifdef SOC_TIMER_IRQ_EN
        always_ff @(posedge clk) begin
            if (!res) ie <= 1'b0;
            else ie <= (hit && rsel == 4'd0) ? wdata[8] : ie;
        end
        assign irq_src[i] = flag && ie;
`else
        assign ie = 1'b0;
`endif
        assign timer_counts[i] = cnt;
        assign rv[i] = rsel == 4'd0 ? {23'd0, ie, 6'd0, os, en} :
                       rsel == 4'd1 ? top :
                       rsel == 4'd2 ? {16'd0, pre} :
                       rsel == 4'd3 ? cnt :
                       rsel == 4'd4 ? {31'd0, flag} : 32'd0;
    end
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < TIMER_COUNT; k++)
            if (typ == 2'd0 && idx == 4'(k)) rd_data = rv[k];
    end
`ifdef SOC_TIMER_IRQ_EN
    always_ff @(posedge clk) begin
        if (!res) irq <= 1'b0;
        else irq <= |irq_src;
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_soc_timer.sv
// tb_soc_timer: directed and randomized checks of soc_timer (TIMER_COUNT=2) against a behavioural model.
module tb_soc_timer;
    localparam int TC = 2;
`ifdef SOC_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [31:0] counts [TC];
    logic        irq;
    int          vectors = 0;
    int          miscompares = 0;
    SoC_MemBus bus();

    soc_timer #(.BUS_LATENCY(1), .TIMER_COUNT(TC)) dut (
        .clk(clk), .res(res), .timer_counts(counts), .irq(irq), .mem_bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Reference model: state as the specification describes it, advanced once per rising edge.
    logic        m_en [TC], m_os [TC], m_ie [TC], m_flag [TC];
    logic [31:0] m_top [TC], m_cnt [TC];
    logic [15:0] m_pre [TC], m_age [TC];
    logic        m_irq;

    always @(posedge clk) begin
        logic tk, wp, old_os, w, irq_n;
        int ai, ar, at;
        if (!res) begin
            for (int t = 0; t < TC; t++) begin
                m_en[t] = 0; m_os[t] = 0; m_ie[t] = 0; m_flag[t] = 0;
                m_top[t] = 0; m_cnt[t] = 0; m_pre[t] = 0; m_age[t] = 0;
            end
            m_irq = 0;
        end else begin
            irq_n = 0;
            for (int t = 0; t < TC; t++) irq_n = irq_n | (m_flag[t] & m_ie[t]);
            ai = int'(bus.addr[11:8]);
            ar = int'(bus.addr[7:4]);
            at = int'(bus.addr[3:2]);
            w = bus.req && bus.we && at == 0 && ai < TC;
            for (int t = 0; t < TC; t++) begin
                tk = 0;
                wp = 0;
                old_os = m_os[t];
                if (!m_en[t]) m_age[t] = 0;
                else if (m_age[t] == m_pre[t]) begin tk = 1; m_age[t] = 0; end
                else m_age[t] = m_age[t] + 1;
                if (w && ai == t && ar == 3) m_cnt[t] = bus.wdata;
                else if (tk) begin
                    if (m_cnt[t] < m_top[t]) m_cnt[t] = m_cnt[t] + 1;
                    else begin m_cnt[t] = 0; wp = 1; end
                end
                if (w && ai == t && ar == 1) m_top[t] = bus.wdata;
                if (w && ai == t && ar == 2) m_pre[t] = bus.wdata[15:0];
                if (w && ai == t && ar == 0) begin
                    m_en[t] = bus.wdata[0];
                    m_os[t] = bus.wdata[1];
                    m_ie[t] = bus.wdata[8] & IRQ_ON;
                end
                if (wp && old_os) m_en[t] = 0;
                if (w && ai == t && ar == 4) m_flag[t] = bus.wdata[0];
                if (wp) m_flag[t] = 1;
            end
            m_irq = irq_n & IRQ_ON;
        end
    end

    function automatic logic [31:0] model_rd(int idx, int rg, int typ);
        if (typ != 0 || idx >= TC) return 32'd0;
        case (rg)
            0: return {23'd0, m_ie[idx], 6'd0, m_os[idx], m_en[idx]};
            1: return m_top[idx];
            2: return {16'd0, m_pre[idx]};
            3: return m_cnt[idx];
            4: return {31'd0, m_flag[idx]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int idx, input int rg, input int typ, input logic [31:0] val);
        bus.req = 1; bus.we = 1; bus.wdata = val;
        bus.addr = {20'd0, 4'(idx), 4'(rg), 2'(typ), 2'd0};
        cyc();
        bus.req = 0; bus.we = 0;
    endtask

    task automatic bus_read(input int idx, input int rg, input int typ,
                            output logic [31:0] data, output logic [31:0] exp);
        int n;
        exp = model_rd(idx, rg, typ);
        bus.req = 1; bus.we = 0;
        bus.addr = {20'd0, 4'(idx), 4'(rg), 2'(typ), 2'd0};
        cyc();
        bus.req = 0;
        n = 0;
        while (!bus.rvalid && n < 8) begin cyc(); n++; end
        vectors++;
        if (bus.rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_timeout: rvalid=%b expected 1", bus.rvalid);
        end
        data = bus.rdata;
    endtask

    task automatic do_reset();
        res = 0;
        cyc();
        cyc();
        res = 1;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        do_reset();
        for (int t = 0; t < TC; t++) begin
            vectors++;
            if (counts[t] !== 32'd0) begin miscompares++; $display("FAIL reset_count%0d: got %0h expected 0", t, counts[t]); end
        end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
        bus_read(0, 0, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL reset_ctrl: got %0h expected 0", d); end
        bus_read(1, 4, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL reset_status: got %0h expected 0", d); end
    endtask

    task automatic test_wrap_sequence();
        logic [31:0] d, e;
        do_reset();
        bus_write(0, 1, 0, 32'd3);
        bus_write(0, 0, 0, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            vectors++;
            if (counts[0] !== 32'(k % 4)) begin miscompares++; $display("FAIL seq_count k=%0d: got %0h expected %0h", k, counts[0], k % 4); end
        end
        bus_read(0, 4, 0, d, e);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL seq_flag_set: got %0h expected 1", d); end
        bus_write(0, 4, 0, 32'd0);
        vectors++;
        if (counts[0] !== 32'd2) begin miscompares++; $display("FAIL seq_count_after_clear: got %0h expected 2", counts[0]); end
        bus_read(0, 4, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL seq_flag_cleared: got %0h expected 0", d); end
        cyc();
        vectors++;
        if (counts[0] !== 32'd0) begin miscompares++; $display("FAIL seq_rewrap: got %0h expected 0", counts[0]); end
        bus_read(0, 4, 0, d, e);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL seq_flag_again: got %0h expected 1", d); end
    endtask

    task automatic test_prescale();
        do_reset();
        bus_write(0, 1, 0, 32'd10);
        bus_write(0, 2, 0, 32'd2);
        bus_write(0, 0, 0, 32'd1);
        for (int n = 1; n <= 9; n++) begin
            cyc();
            vectors++;
            if (counts[0] !== 32'(n / 3)) begin miscompares++; $display("FAIL prescale n=%0d: got %0h expected %0h", n, counts[0], n / 3); end
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d, e;
        int exp_seq [5] = '{1, 2, 0, 0, 0};
        do_reset();
        bus_write(0, 1, 0, 32'd2);
        bus_write(0, 0, 0, 32'h3);
        for (int n = 0; n < 5; n++) begin
            cyc();
            vectors++;
            if (counts[0] !== 32'(exp_seq[n])) begin miscompares++; $display("FAIL oneshot n=%0d: got %0h expected %0h", n + 1, counts[0], exp_seq[n]); end
        end
        bus_read(0, 0, 0, d, e);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL oneshot_ctrl: got %0h expected 2", d); end
        bus_read(0, 4, 0, d, e);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL oneshot_flag: got %0h expected 1", d); end
        bus_read(0, 3, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL oneshot_rest: got %0h expected 0", d); end
    endtask

    task automatic test_count_write();
        logic [31:0] d, e;
        do_reset();
        bus_write(0, 1, 0, 32'd7);
        bus_write(0, 0, 0, 32'd1);
        repeat (7) cyc();
        vectors++;
        if (counts[0] !== 32'd7) begin miscompares++; $display("FAIL cw_reach: got %0h expected 7", counts[0]); end
        bus_write(0, 3, 0, 32'd7);
        vectors++;
        if (counts[0] !== 32'd7) begin miscompares++; $display("FAIL cw_value: got %0h expected 7", counts[0]); end
        bus_read(0, 4, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL cw_no_wrap: got %0h expected 0", d); end
        vectors++;
        if (counts[0] !== 32'd0) begin miscompares++; $display("FAIL cw_next_tick: got %0h expected 0", counts[0]); end
        bus_read(0, 4, 0, d, e);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL cw_wrap_flag: got %0h expected 1", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d, e;
        do_reset();
        bus_write(0, 1, 0, 32'd1);
        bus_write(0, 0, 0, 32'h101);
        cyc();
        cyc();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_latency: got %b expected 0", irq); end
        cyc();
        vectors++;
        if (irq !== IRQ_ON) begin miscompares++; $display("FAIL irq_raise: got %b expected %b", irq, IRQ_ON); end
        bus_write(0, 4, 0, 32'd0);
        vectors++;
        if (counts[0] !== 32'd0) begin miscompares++; $display("FAIL irq_wrap_count: got %0h expected 0", counts[0]); end
        bus_read(0, 4, 0, d, e);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL irq_set_priority: got %0h expected 1", d); end
        bus_read(0, 0, 0, d, e);
        vectors++;
        if (d !== {23'd0, IRQ_ON, 8'h01}) begin miscompares++; $display("FAIL irq_ctrl_read: got %0h expected %0h", d, {23'd0, IRQ_ON, 8'h01}); end
        bus_write(0, 0, 0, 32'd0);
        bus_write(0, 4, 0, 32'd0);
        cyc();
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_multi_reset();
        logic [31:0] d, e;
        do_reset();
        bus_write(0, 1, 0, 32'd5);
        bus_write(1, 1, 0, 32'd9);
        bus_write(0, 0, 0, 32'd1);
        bus_write(1, 0, 0, 32'd1);
        for (int n = 1; n <= 7; n++) begin
            cyc();
            vectors++;
            if (counts[0] !== 32'((n + 1) % 6)) begin miscompares++; $display("FAIL multi_t0 n=%0d: got %0h expected %0h", n, counts[0], (n + 1) % 6); end
            vectors++;
            if (counts[1] !== 32'(n % 10)) begin miscompares++; $display("FAIL multi_t1 n=%0d: got %0h expected %0h", n, counts[1], n % 10); end
        end
        res = 0;
        cyc();
        for (int t = 0; t < TC; t++) begin
            vectors++;
            if (counts[t] !== 32'd0) begin miscompares++; $display("FAIL midrun_reset%0d: got %0h expected 0", t, counts[t]); end
        end
        res = 1;
        bus_write(2, 1, 0, 32'h55);
        bus_write(0, 1, 1, 32'h66);
        bus_read(2, 3, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL idx2_read: got %0h expected 0", d); end
        bus_read(0, 1, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL ignored_writes: got %0h expected 0", d); end
        bus_read(0, 5, 0, d, e);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL unmapped_reg: got %0h expected 0", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, e, val;
        int r, idx, rg, typ;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 39);
            idx = $urandom_range(0, 3);
            rg = $urandom_range(0, 7);
            typ = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            if (r == 0) begin
                res = 0;
                cyc();
                res = 1;
            end else if (r < 16) begin
                case (rg)
                    0: begin val = $urandom; val[0] = ($urandom_range(0, 3) != 0); end
                    1: val = $urandom_range(0, 6);
                    2: val = $urandom_range(0, 3);
                    3: val = $urandom_range(0, 8);
                    4: val = $urandom_range(0, 1);
                    default: val = $urandom;
                endcase
                bus_write(idx, rg, typ, val);
            end else if (r < 24) begin
                bus_read(idx, rg, typ, d, e);
                vectors++;
                if (d !== e) begin miscompares++; $display("FAIL rand_read i%0d r%0d t%0d: got %0h expected %0h", idx, rg, typ, d, e); end
            end else cyc();
            for (int t = 0; t < TC; t++) begin
                vectors++;
                if (counts[t] !== m_cnt[t]) begin miscompares++; $display("FAIL rand_count%0d c=%0d: got %0h expected %0h", t, c, counts[t], m_cnt[t]); end
            end
            vectors++;
            if (irq !== m_irq) begin miscompares++; $display("FAIL rand_irq c=%0d: got %b expected %b", c, irq, m_irq); end
        end
    endtask

    initial begin
        bus.req = 0; bus.we = 0; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_wrap_sequence();
        test_prescale();
        test_one_shot();
        test_count_write();
        test_irq();
        test_multi_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
